// File: rtl/bcd_countdown_timer.sv
// Purpose : multi-digit packed-BCD countdown/count-up timer with load, start,
//           pause/resume and expiry; optional auto-reload via AUTO_RELOAD_EN.
// Latency : step visible SCALE_FACTOR cycles after the start edge, then every
//           SCALE_FACTOR cycles; done/expired registered with the state.
// Backpressure: none; pause freezes count and tick, only load/reset leave EXPIRED.
//
// Ports:
//   CLOCK_50   clock; reset synchronous active-high
//   load       loads load_value/count_up (digits >9 clamped to 9), state -> IDLE
//   start      pulse: IDLE/PAUSED -> RUNNING (IDLE with count==target -> EXPIRED)
//   pause      pulse: RUNNING -> PAUSED; beats start in the same cycle
//   digits     current count, packed BCD, digit 0 in [3:0]
//   running    state is RUNNING
//   expired    state is EXPIRED
//   done       one-cycle pulse on entry to EXPIRED (or on each reload)
// Macro AUTO_RELOAD_EN: on reaching target, reload the start value and keep running.
module bcd_countdown_timer #(
  parameter int NUM_DIGITS   = 4,
  parameter int SCALE_FACTOR = 50_000_000
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    count_up,
  input  logic                    start,
  input  logic                    pause,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    running,
  output logic                    expired,
  output logic                    done
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int TW = (SCALE_FACTOR > 1) ? $clog2(SCALE_FACTOR) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SCALE_FACTOR - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUNNING = 2'd1,
    S_PAUSED  = 2'd2,
    S_EXPIRED = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    count_q, count_d;
  logic [W-1:0]    target_q, target_d;
  logic [TW-1:0]   tick_q, tick_d;
  logic            up_q, up_d;
  logic            done_q, done_d;
  logic [W-1:0]    clamped;
  logic [W-1:0]    stepped;
`ifdef AUTO_RELOAD_EN
  logic [W-1:0]    reload_q, reload_d;
`endif

  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r[4*i +: 4] > 4'd9) r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  // Ripple a +1/-1 through the digits; a digit only changes while the
  // carry/borrow from below is still live.
  function automatic logic [W-1:0] bcd_step(input logic [W-1:0] v, input logic up);
    logic [W-1:0] r;
    logic         c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (c) begin
        if (up) begin
          if (r[4*i +: 4] == 4'd9) begin
            r[4*i +: 4] = 4'd0;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] + 4'd1;
            c = 1'b0;
          end
        end else begin
          if (r[4*i +: 4] == 4'd0) begin
            r[4*i +: 4] = 4'd9;
          end else begin
            r[4*i +: 4] = r[4*i +: 4] - 4'd1;
            c = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  assign clamped = bcd_clamp(load_value);
  assign stepped = bcd_step(count_q, up_q);

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    target_d = target_q;
    tick_d   = tick_q;
    up_d     = up_q;
    done_d   = 1'b0;
`ifdef AUTO_RELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      up_d     = count_up;
      count_d  = count_up ? '0 : clamped;
      target_d = count_up ? clamped : '0;
`ifdef AUTO_RELOAD_EN
      reload_d = count_up ? '0 : clamped;
`endif
      tick_d   = '0;
      state_d  = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (count_q == target_q) begin
              state_d = S_EXPIRED;
              done_d  = 1'b1;
            end else begin
              state_d = S_RUNNING;
            end
          end
        end
        S_RUNNING: begin
          if (pause) begin
            state_d = S_PAUSED;
          end else if (tick_q == TICK_LAST) begin
            tick_d  = '0;
            count_d = stepped;
            if (stepped == target_q) begin
              done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
              count_d = reload_q;
`else
              state_d = S_EXPIRED;
`endif
            end
          end else begin
            tick_d = tick_q + TW'(1);
          end
        end
        S_PAUSED: begin
          if (start && !pause) state_d = S_RUNNING;
        end
        default: ;  // S_EXPIRED: only load or reset leave
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      count_q  <= '0;
      target_q <= '0;
      tick_q   <= '0;
      up_q     <= 1'b0;
      done_q   <= 1'b0;
`ifdef AUTO_RELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      target_q <= target_d;
      tick_q   <= tick_d;
      up_q     <= up_d;
      done_q   <= done_d;
`ifdef AUTO_RELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign digits  = count_q;
  assign running = (state_q == S_RUNNING);
  assign expired = (state_q == S_EXPIRED);
  assign done    = done_q;

endmodule
